// File: rtl/bram_port_server_if.sv
// Request/response bus between a requester and bram_port_server.
// master: requester side; slave: server side.
interface bram_port_server_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WRITE;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_DATA;
  logic                  RESP_VALID;
  logic                  RESP_READY;
  logic [DATA_WIDTH-1:0] RESP_DATA;

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA, RESP_READY,
    input  REQ_READY, RESP_VALID, RESP_DATA
  );

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_DATA, RESP_READY,
    output REQ_READY, RESP_VALID, RESP_DATA
  );
endinterface

// File: rtl/bram_port_server.sv
// Credit-issued request/response front end for one write-first BRAM port.
// Ports: CLK/RST, req (slave bus), BRAM_EN/WE/ADDR/DI out, BRAM_DO in.
module bram_port_server #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 512,
  parameter int PIPELINED  = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  bram_port_server_if.slave     req,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);
  localparam int L  = 1 + PIPELINED;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [L-1:0]          pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic                  ready, acc, rd_acc, push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    // Credits cover in-flight reads plus queued data,
    // so the FIFO always has room when BRAM_DO lands.
    ready  = !RST && (cnt_q < FULL);
    acc    = req.REQ_VALID && ready;
    rd_acc = acc && !req.REQ_WRITE;
    push   = pipe_q[L-1];
    pop    = (occ_q != '0) && req.RESP_READY;
    pipe_d = L'({pipe_q, rd_acc});
    cnt_d  = cnt_q;
    case ({rd_acc, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    wptr_d = push ? inc(wptr_q) : wptr_q;
    rptr_d = pop  ? inc(rptr_q) : rptr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      occ_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      pipe_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      occ_q  <= occ_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      pipe_q <= pipe_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= BRAM_DO;
  end

  assign req.REQ_READY  = ready;
  assign req.RESP_VALID = (occ_q != '0);
  assign req.RESP_DATA  = mem_q[rptr_q];

  assign BRAM_EN   = acc;
  assign BRAM_WE   = req.REQ_WRITE;
  assign BRAM_ADDR = req.REQ_ADDR;
  assign BRAM_DI   = req.REQ_DATA;

  a_no_overflow: assert property (
    @(posedge CLK) disable iff (RST) !(push && (occ_q == FULL))
  );
endmodule
